// File: rtl/monolith_sif_pkg.sv
// Shared types and defaults for the Monolith AXI4-Stream slave front end.
// Build option: MONOLITH_SIF_TLAST_PAD_EN (TLAST closes a chunk early, tail words read as zero).
package monolith_sif_pkg;

  localparam int DEF_CHUNK_SIZE  = 16;
  localparam int DEF_CHUNK_COUNT = 2;
  localparam int DEF_DATA_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } wr_state_e;

  // chunk_len must hold 1..size inclusive
  function automatic int chunk_len_w(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/monolith_chunk_buffer.sv
// Chunk storage: word array plus per-slot len/last flags, with a combinational read of one slot.
// Build option: MONOLITH_SIF_TLAST_PAD_EN zeroes words at index >= len on the read side.
module monolith_chunk_buffer
  import monolith_sif_pkg::*;
#(
  parameter int CHUNK_SIZE  = DEF_CHUNK_SIZE,
  parameter int CHUNK_COUNT = DEF_CHUNK_COUNT,
  parameter int DATA_W      = DEF_DATA_W,
  localparam int WORD_W     = $clog2(CHUNK_SIZE),
  localparam int SLOT_W     = $clog2(CHUNK_COUNT),
  localparam int LEN_W      = chunk_len_w(CHUNK_SIZE)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_chunk,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              close_en,
  input  logic [LEN_W-1:0]  close_len,
  input  logic              close_last,
  input  logic [SLOT_W-1:0] rd_chunk,
  output logic [DATA_W-1:0] rd_words [CHUNK_SIZE],
  output logic [LEN_W-1:0]  rd_len,
  output logic              rd_last
);

  logic [DATA_W-1:0] mem       [CHUNK_COUNT][CHUNK_SIZE];
  logic [LEN_W-1:0]  slot_len  [CHUNK_COUNT];
  logic              slot_last [CHUNK_COUNT];

  // Storage is deliberately not reset; the top qualifies everything with its occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_chunk][wr_word] <= wr_data;
    if (close_en) begin
      slot_len[wr_chunk]  <= close_len;
      slot_last[wr_chunk] <= close_last;
    end
  end

  assign rd_len  = slot_len[rd_chunk];
  assign rd_last = slot_last[rd_chunk];

  for (genvar i = 0; i < CHUNK_SIZE; i++) begin : g_rd
`ifdef MONOLITH_SIF_TLAST_PAD_EN
    // Stale words from an earlier, longer chunk are masked so a short chunk reads zero-padded.
    assign rd_words[i] = (LEN_W'(i) < rd_len) ? mem[rd_chunk][i] : '0;
`else
    assign rd_words[i] = mem[rd_chunk][i];
`endif
  end

endmodule

// File: rtl/monolith_axis_ip_slave_sif.sv
// AXI4-Stream slave that packs 32-bit words into chunks and presents them in parallel to the core.
// Build option: MONOLITH_SIF_TLAST_PAD_EN lets TLAST close a chunk early with a short chunk_len.
module monolith_axis_ip_slave_sif
  import monolith_sif_pkg::*;
#(
  parameter int FIFO_CHUNK_SIZE      = DEF_CHUNK_SIZE,
  parameter int FIFO_CHUNK_COUNT     = DEF_CHUNK_COUNT,
  parameter int C_S_AXIS_TDATA_WIDTH = DEF_DATA_W
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic                              S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   chunk_out [FIFO_CHUNK_SIZE],
  output logic                              chunk_valid,
  input  logic                              chunk_ready,
  output logic                              chunk_last,
  output logic [chunk_len_w(FIFO_CHUNK_SIZE)-1:0] chunk_len
);

  localparam int WORD_W = $clog2(FIFO_CHUNK_SIZE);
  localparam int SLOT_W = $clog2(FIFO_CHUNK_COUNT);
  localparam int USED_W = $clog2(FIFO_CHUNK_COUNT + 1);
  localparam int LEN_W  = chunk_len_w(FIFO_CHUNK_SIZE);

  logic [WORD_W-1:0] wr_word;
  logic [SLOT_W-1:0] wr_chunk, rd_chunk;
  logic [USED_W-1:0] used, used_nxt;
  logic              last_acc;
  wr_state_e         state, state_nxt;

  logic              accept, close_en, pop, pad_close;
  logic [LEN_W-1:0]  close_len, rd_len;
  logic              rd_last;
  logic              unused_strb;

  assign unused_strb = ^S_AXIS_TSTRB;

`ifdef MONOLITH_SIF_TLAST_PAD_EN
  assign pad_close = S_AXIS_TLAST;
  assign close_len = LEN_W'(wr_word) + LEN_W'(1);
`else
  assign pad_close = 1'b0;
  assign close_len = LEN_W'(FIFO_CHUNK_SIZE);
`endif

  // TREADY comes from state only; gating with reset keeps it low while reset is held.
  assign S_AXIS_TREADY = S_AXIS_ARESETN && (state != FULL);
  assign chunk_valid   = (used != '0);
  assign chunk_len     = chunk_valid ? rd_len : '0;
  assign chunk_last    = chunk_valid && rd_last;

  assign accept   = S_AXIS_TVALID && S_AXIS_TREADY;
  assign close_en = accept && ((wr_word == WORD_W'(FIFO_CHUNK_SIZE - 1)) || pad_close);
  assign pop      = chunk_valid && chunk_ready;

  always_comb begin
    used_nxt = used;
    case ({close_en, pop})
      2'b10:   used_nxt = used + USED_W'(1);
      2'b01:   used_nxt = used - USED_W'(1);
      default: used_nxt = used;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FILL: begin
        if (close_en)    state_nxt = (used_nxt == USED_W'(FIFO_CHUNK_COUNT)) ? FULL : IDLE;
        else if (accept) state_nxt = FILL;
      end
      FULL:    if (pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state    <= IDLE;
      used     <= '0;
      wr_word  <= '0;
      wr_chunk <= '0;
      rd_chunk <= '0;
      last_acc <= 1'b0;
    end else begin
      state <= state_nxt;
      used  <= used_nxt;
      if (accept) begin
        if (close_en) begin
          wr_word  <= '0;
          wr_chunk <= wr_chunk + SLOT_W'(1);
          last_acc <= 1'b0;
        end else begin
          wr_word  <= wr_word + WORD_W'(1);
          last_acc <= last_acc | S_AXIS_TLAST;
        end
      end
      if (pop) rd_chunk <= rd_chunk + SLOT_W'(1);
    end
  end

  monolith_chunk_buffer #(
    .CHUNK_SIZE (FIFO_CHUNK_SIZE),
    .CHUNK_COUNT(FIFO_CHUNK_COUNT),
    .DATA_W     (C_S_AXIS_TDATA_WIDTH)
  ) u_buf (
    .clk       (S_AXIS_ACLK),
    .wr_en     (accept),
    .wr_chunk  (wr_chunk),
    .wr_word   (wr_word),
    .wr_data   (S_AXIS_TDATA),
    .close_en  (close_en),
    .close_len (close_len),
    .close_last(last_acc | S_AXIS_TLAST),
    .rd_chunk  (rd_chunk),
    .rd_words  (chunk_out),
    .rd_len    (rd_len),
    .rd_last   (rd_last)
  );

endmodule
